// File: rtl/lzd_normalizer.sv
// lzd_normalizer: strips the leading-ones run reported by the detector
// with a multi-cycle left shift, then emits mantissa and exponent.
module lzd_normalizer #(
  parameter int W          = 61,
  parameter int SHIFT_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [6:0]   in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] norm_data,
  output logic [5:0]   exp,
  output logic         err
);

  localparam logic [5:0] W6   = 6'(W);
  localparam logic [6:0] W7   = 7'(W);
  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] data_r;
  logic [W-1:0] shifted;
  logic [5:0]   rem;
  logic [5:0]   pos;
  logic [5:0]   s;
  logic         nb;
  logic         pos_bad;
  logic         accept;
  logic         step;
  logic         last;

  assign pos     = in_code[6:1];
  assign pos_bad = (pos == 6'd0) || ({1'b0, pos} > W7);
  assign accept  = in_valid && in_ready;
  assign step    = (state == SHIFT);
  assign s       = (rem > STEP) ? STEP : rem;
  assign shifted = data_r << s;
  // rem - s == 0 exactly when the clamp did not bite
  assign last    = (rem == s);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = pos_bad ? HOLD : SHIFT;
      SHIFT:   if (last) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r <= '0;
      rem    <= '0;
      exp    <= '0;
      nb     <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (1'b1)
        accept && !pos_bad: begin
          data_r <= in_data;
          rem    <= pos;
          exp    <= pos;
          nb     <= in_code[0];
          err    <= 1'b0;
        end
        accept && pos_bad: begin
          data_r <= '0;
          rem    <= '0;
          exp    <= pos;
          nb     <= in_code[0];
          err    <= 1'b1;
        end
        step: begin
          data_r <= shifted;
          rem    <= rem - s;
          // a full-width strip leaves no bit to compare
          if (last)
            err <= (exp < W6) && (shifted[W-1] != nb);
        end
        default: begin
        end
      endcase
    end
  end

  assign norm_data = data_r;

  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst)
    out_valid && !out_ready |=>
      out_valid && $stable(norm_data) &&
      $stable(exp) && $stable(err)
  );

endmodule
